// File: rtl/word_packer_2to1.sv
// Packs pairs of WIDTH-bit words into 2*WIDTH-bit beats (lane0 = first word).
// A packet ending on a lane0 word produces a half beat with lane1 zeroed.
module word_packer_2to1 #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] rdata,
  output logic [1:0]         out_keep,
  output logic               out_last
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]         keep_q, keep_d;
  logic               last_q, last_d;
  logic               valid_q, valid_d;
  logic               in_hs_s;
  logic               out_hs_s;

  // Accepting a word while FULL is only possible when the beat leaves on the same edge.
  assign in_ready = (state_q == ST_FULL) ? out_ready : 1'b1;
  assign in_hs_s  = in_valid && in_ready;
  assign out_hs_s = valid_q && out_ready;

  assign out_valid = valid_q;
  assign rdata     = rdata_q;
  assign out_keep  = keep_q;
  assign out_last  = last_q;

  // Next-state and lane loading.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    keep_d  = keep_q;
    last_d  = last_q;
    valid_d = valid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_hs_s) begin
          rdata_d = {{WIDTH{1'b0}}, wdata};
          if (in_last) begin
            state_d = ST_FULL;
            keep_d  = 2'b01;
            last_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            state_d = ST_HALF;
            keep_d  = 2'b00;
            last_d  = 1'b0;
            valid_d = 1'b0;
          end
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_HALF: begin
        if (in_hs_s) begin
          rdata_d = {wdata, rdata_q[WIDTH-1:0]};
          state_d = ST_FULL;
          keep_d  = 2'b11;
          last_d  = in_last;
          valid_d = 1'b1;
        end else begin
          state_d = ST_HALF;
        end
      end
      ST_FULL: begin
        if (out_hs_s && in_hs_s) begin
          rdata_d = {{WIDTH{1'b0}}, wdata};
          if (in_last) begin
            state_d = ST_FULL;
            keep_d  = 2'b01;
            last_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            state_d = ST_HALF;
            keep_d  = 2'b00;
            last_d  = 1'b0;
            valid_d = 1'b0;
          end
        end else if (out_hs_s) begin
          state_d = ST_EMPTY;
          rdata_d = {(2*WIDTH){1'b0}};
          keep_d  = 2'b00;
          last_d  = 1'b0;
          valid_d = 1'b0;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        rdata_d = {(2*WIDTH){1'b0}};
        keep_d  = 2'b00;
        last_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      rdata_q <= {(2*WIDTH){1'b0}};
      keep_q  <= 2'b00;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_word_packer_2to1.sv
// Directed scenarios plus randomized traffic checked against a packet-level model.
module tb_word_packer_2to1;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   wdata;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] rdata;
  logic [1:0]     out_keep;
  logic           out_last;

  int vectors;
  int miscompares;

  word_packer_2to1 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .wdata(wdata), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .rdata(rdata), .out_keep(out_keep), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] w, input logic il, input logic ordy);
    in_valid  = iv;
    wdata     = w;
    in_last   = il;
    out_ready = ordy;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 32'h1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h2, 1'b1, 1'b0);
    tick();
    // beat now presented; reset with garbage on inputs
    drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || out_keep !== 2'b00 || out_last !== 1'b0 || rdata !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b keep=%b last=%b rdata=%h, want 0/00/0/0", out_valid, out_keep, out_last, rdata);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_pair();
    do_reset();
    drive(1'b1, 32'hA5A5_1234, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || rdata !== 64'hDEADBEEF_A5A51234 || out_keep !== 2'b11 || out_last !== 1'b1) begin
      miscompares++;
      $display("FAIL pair_beat: valid=%b rdata=%h keep=%b last=%b want 1 deadbeefa5a51234 11 1", out_valid, rdata, out_keep, out_last);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pair_one_cycle: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    drive(1'b1, 32'h0000_0042, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || rdata !== 64'h00000000_00000042 || out_keep !== 2'b01 || out_last !== 1'b1) begin
      miscompares++;
      $display("FAIL single_beat: valid=%b rdata=%h keep=%b last=%b want 1 42 01 1", out_valid, rdata, out_keep, out_last);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_once: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b1, 32'h1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h2, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h99 + i, 1'b1, 1'b0);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || rdata !== 64'h00000002_00000001 || out_keep !== 2'b11 || out_last !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: in_ready=%b valid=%b rdata=%h keep=%b last=%b", i, in_ready, out_valid, rdata, out_keep, out_last);
      end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    vectors++;
    if (in_ready !== 1'b1 || rdata !== 64'h00000002_00000001) begin
      miscompares++;
      $display("FAIL bp_release: in_ready=%b rdata=%h want 1 0000000200000001", in_ready, rdata);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_retired: valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(1'b1, 32'h1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h2, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h3, 1'b0, 1'b1);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL sim_no_bubble: in_ready=%b valid=%b want 1 1", in_ready, out_valid);
    end
    tick();
    drive(1'b1, 32'h4, 1'b1, 1'b1);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL sim_half: out_valid=%b want 0", out_valid);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || rdata !== 64'h00000004_00000003 || out_keep !== 2'b11 || out_last !== 1'b1) begin
      miscompares++;
      $display("FAIL sim_next_beat: valid=%b rdata=%h keep=%b last=%b", out_valid, rdata, out_keep, out_last);
    end
    tick();
  endtask

  task automatic test_streaming();
    logic [2*W-1:0] exp_d;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      if (k < 8) drive(1'b1, k, (k == 7), 1'b1);
      else       drive(1'b0, '0, 1'b0, 1'b1);
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_ready[%0d]: in_ready=%b want 1", k, in_ready);
      end
      tick();
      exp_d = {32'(k), 32'(k - 1)};
      vectors++;
      if (k % 2 == 1) begin
        if (out_valid !== 1'b1 || rdata !== exp_d || out_keep !== 2'b11 || out_last !== (k == 7)) begin
          miscompares++;
          $display("FAIL stream_beat[%0d]: valid=%b rdata=%h keep=%b last=%b want rdata %h", k, out_valid, rdata, out_keep, out_last, exp_d);
        end
      end else if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stream_gap[%0d]: out_valid=%b want 0", k, out_valid);
      end
    end
  endtask

  task automatic test_reset_mid_pair();
    do_reset();
    drive(1'b1, 32'h11, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_after_rst: valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    drive(1'b1, 32'h22, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_keep !== 2'b01 || rdata !== 64'h00000000_00000022 || out_last !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_beat: valid=%b keep=%b rdata=%h last=%b want 1 01 22 1", out_valid, out_keep, rdata, out_last);
    end
    tick();
  endtask

  typedef struct {
    logic [2*W-1:0] data;
    logic [1:0]     keep;
    logic           last;
  } beat_t;

  task automatic test_random();
    beat_t        beats[$];
    logic [W-1:0] words[$];
    beat_t        b;
    logic         iv, il, ordy, exp_rdy, in_hs, out_hs;
    logic [W-1:0] w;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      iv   = ($urandom_range(0, 3) != 0);
      il   = ($urandom_range(0, 2) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      w    = $urandom;
      drive(iv, w, il, ordy);
      exp_rdy = (beats.size() == 0) || ordy;
      vectors++;
      if (in_ready !== exp_rdy || out_valid !== (beats.size() != 0)) begin
        miscompares++;
        $display("FAIL rand_hs[%0d]: in_ready=%b valid=%b want %b %b", c, in_ready, out_valid, exp_rdy, beats.size() != 0);
      end
      if (beats.size() != 0) begin
        vectors++;
        if (rdata !== beats[0].data || out_keep !== beats[0].keep || out_last !== beats[0].last) begin
          miscompares++;
          $display("FAIL rand_beat[%0d]: rdata=%h keep=%b last=%b want %h %b %b", c, rdata, out_keep, out_last, beats[0].data, beats[0].keep, beats[0].last);
        end
      end
      in_hs  = iv && exp_rdy;
      out_hs = (beats.size() != 0) && ordy;
      tick();
      if (out_hs) void'(beats.pop_front());
      if (in_hs) begin
        words.push_back(w);
        if (words.size() == 2) begin
          b.data = {words[1], words[0]};
          b.keep = 2'b11;
          b.last = il;
          beats.push_back(b);
          words.delete();
        end else if (il) begin
          b.data = {32'h0, words[0]};
          b.keep = 2'b01;
          b.last = 1'b1;
          beats.push_back(b);
          words.delete();
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    wdata       = '0;
    in_last     = 1'b0;
    out_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_pair();
    test_single();
    test_backpressure();
    test_simultaneous();
    test_streaming();
    test_reset_mid_pair();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
